uart_link: RTL and testbench
============================

Name: uart_link

Overview:
- Single-clock 8N1 UART endpoint that bundles a transmitter and a receiver sharing one bit-period parameterisation.
- TX path serialises bytes from a valid/ready stream onto `bit_out`.
- RX path deserialises `bit_in` into a one-entry valid/ready output register.
- Sits between byte-stream logic and the board serial pins; with `bit_out` tied to `bit_in` it forms a loopback.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 3000000, line rate in bits/s.
- CLKS_PER_BIT (localparam) = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, rounded to nearest; 33 at defaults. Must be >= 4.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- byte_in_data  input  8  TX byte.
- byte_in_valid  input  1  TX byte offered.
- byte_in_ready  output  1  TX can accept a byte.
- bit_out  output  1  serial line out, idle high.
- bit_in  input  1  serial line in, asynchronous to clk.
- byte_out_data  output  8  received byte.
- byte_out_valid  output  1  received byte available.
- byte_out_ready  input  1  consumer accepts the byte.
- rx_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_overrun  output  1  one-cycle pulse when a good byte is dropped because the holding register is full.

Behaviour:
- Reset values: bit_out=1, byte_in_ready=0, byte_out_valid=0, byte_out_data=0, rx_frame_err=0, rx_overrun=0. Both FSMs go to IDLE; the RX synchroniser flops are set to 1.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Every bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, STOP.
- IDLE: byte_in_ready=1 (registered; first asserted the cycle after rst deasserts).
- A transfer occurs when byte_in_valid && byte_in_ready. On that edge:
  - the byte is latched;
  - the FSM enters START;
  - byte_in_ready drops;
  - bit_out goes 0 on the same edge, so the start bit begins 1 cycle after acceptance.
- START lasts CLKS_PER_BIT cycles, then DATA shifts out bits 0..7, each CLKS_PER_BIT cycles, then STOP drives 1 for CLKS_PER_BIT cycles.
- At the end of STOP the FSM returns to IDLE and byte_in_ready=1. A byte offered then starts the next frame immediately, giving 10*CLKS_PER_BIT+1 cycles per back-to-back byte.
- byte_in_data and byte_in_valid are ignored while byte_in_ready=0.
- RX input: bit_in passes through a 2-flop synchroniser; all logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE: a synchronised 1→0 transition enters START, with the counter cleared.
- START: after CLKS_PER_BIT/2 cycles (integer division, 16), sample the line. If it is 1, treat it as a glitch and return to IDLE with no output. If it is 0, enter DATA.
- DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift into bits 0..7 LSB first.
- STOP: sample once after a further CLKS_PER_BIT cycles, then return to IDLE on the next cycle, ready for a new start edge.
  - Stop=1 and byte_out_valid=0: load byte_out_data and set byte_out_valid.
  - Stop=1 and byte_out_valid=1 with no handshake this cycle: keep the old data and pulse rx_overrun.
  - Stop=1 and byte_out_valid && byte_out_ready in the same cycle: load the new byte and keep valid=1 (no overrun).
  - Stop=0: discard the byte, pulse rx_frame_err, leave byte_out_valid unchanged.
- byte_out_valid clears on the edge where byte_out_valid && byte_out_ready, unless a new byte loads on that same edge.
- byte_out_data is stable while valid=1.
- The TX and RX FSMs are fully independent and may run simultaneously.
- Reset asserted mid-frame: both FSMs abort at once, and all outputs take their reset values asynchronously.
- RX must tolerate ±2% baud mismatch. It must not resynchronise on data-bit edges.

Test Plan:
- Loopback (bit_out→bit_in), defaults, send 0xA5 once rst falls:
  - byte_in_ready low for exactly 330 cycles;
  - bit_out pattern 0,1,0,1,0,0,1,0,1,1, each 33 cycles;
  - byte_out_valid rises with byte_out_data=0xA5 about 314 cycles after acceptance.
- Loopback streaming 0x00, 0xFF, 0x55, 0x80 with valid held high and byte_out_ready=1 → all four received in order, no gaps beyond 1 idle cycle, rx_overrun and rx_frame_err stay 0.
- Two bytes 0x12 then 0x34 with byte_out_ready=0 → byte_out_data stays 0x12, rx_overrun pulses once. Then pulse byte_out_ready → valid clears the next cycle.
- Drive bit_in with frame 0x3C but stop bit 0 → rx_frame_err pulses 1 cycle, byte_out_valid stays 0. A following valid frame 0x3C is received correctly.
- Pulse bit_in low for 10 cycles → no output and no error. The RX FSM is back in IDLE within 20 cycles.
- Assert rst mid-DATA of a TX byte → bit_out=1 and byte_in_ready=0 immediately. After release, byte_in_ready=1 and a new byte 0xC3 transmits correctly.

Source files
------------

// File: rtl/uart_link.sv
// uart_link: single-clock 8N1 UART endpoint (transmitter + receiver).
//
// Both directions use the same bit period, CLKS_PER_BIT, which is derived
// from CLK_FREQ_HZ / BAUD_RATE rounded to nearest. CLKS_PER_BIT must be >= 4.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   byte_in_data   TX byte               byte_in_valid  TX byte offered
//   byte_in_ready  TX can accept a byte (registered)
//   bit_out        serial line out, idle high
//   bit_in         serial line in, asynchronous to clk
//   byte_out_data  received byte, stable while byte_out_valid=1
//   byte_out_valid received byte available
//   byte_out_ready consumer accepts the byte
//   rx_frame_err   one-cycle pulse: stop bit sampled low, byte discarded
//   rx_overrun     one-cycle pulse: good byte dropped, holding register full
module uart_link #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in_data,
  input  logic       byte_in_valid,
  output logic       byte_in_ready,
  output logic       bit_out,
  input  logic       bit_in,
  output logic [7:0] byte_out_data,
  output logic       byte_out_valid,
  input  logic       byte_out_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // ---------------- TX ----------------
  state_t           tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_idx_reg, tx_idx_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic             tx_bit_reg, tx_bit_next;
  logic             tx_ready_reg, tx_ready_next;
  logic             tx_bit_end;
  logic             tx_accept;

  assign tx_bit_end = (tx_cnt_reg == BIT_LAST);
  assign tx_accept  = byte_in_valid && tx_ready_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg <= ST_IDLE;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_bit_reg   <= 1'b1;
      tx_ready_reg <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_idx_reg   <= tx_idx_next;
      tx_shift_reg <= tx_shift_next;
      tx_bit_reg   <= tx_bit_next;
      tx_ready_reg <= tx_ready_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      ST_IDLE:  if (tx_accept) tx_state_next = ST_START;
      ST_START: if (tx_bit_end) tx_state_next = ST_DATA;
      ST_DATA:  if (tx_bit_end && tx_idx_reg == 3'd7) tx_state_next = ST_STOP;
      ST_STOP:  if (tx_bit_end) tx_state_next = ST_IDLE;
      default:  tx_state_next = ST_IDLE;
    endcase
  end

  // bit_out is registered and loaded one bit ahead: the value for the next
  // bit period is computed on the last cycle of the current one.
  always_comb begin
    tx_cnt_next   = tx_bit_end ? '0 : tx_cnt_reg + CNT_W'(1);
    tx_idx_next   = tx_idx_reg;
    tx_shift_next = tx_shift_reg;
    tx_bit_next   = tx_bit_reg;
    tx_ready_next = 1'b0;
    case (tx_state_reg)
      ST_IDLE: begin
        tx_cnt_next   = '0;
        tx_bit_next   = 1'b1;
        tx_ready_next = 1'b1;
        if (tx_accept) begin
          tx_shift_next = byte_in_data;
          tx_idx_next   = '0;
          tx_bit_next   = 1'b0;
          tx_ready_next = 1'b0;
        end
      end
      ST_START: if (tx_bit_end) tx_bit_next = tx_shift_reg[0];
      ST_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx_reg == 3'd7) begin
            tx_bit_next = 1'b1;
          end else begin
            tx_bit_next   = tx_shift_reg[1];
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            tx_idx_next   = tx_idx_reg + 3'd1;
          end
        end
      end
      ST_STOP: if (tx_bit_end) tx_ready_next = 1'b1;
      default: ;
    endcase
  end

  assign byte_in_ready = tx_ready_reg;
  assign bit_out       = tx_bit_reg;

  // ---------------- RX ----------------
  logic             rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
  state_t           rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_idx_reg, rx_idx_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic [7:0]       out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic             frame_err_reg, frame_err_next;
  logic             overrun_reg, overrun_next;
  logic             rx_bit_end, rx_half_end;

  assign rx_bit_end  = (rx_cnt_reg == BIT_LAST);
  assign rx_half_end = (rx_cnt_reg == HALF_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_reg  <= 1'b1;
      rx_sync2_reg  <= 1'b1;
      rx_prev_reg   <= 1'b1;
      rx_state_reg  <= ST_IDLE;
      rx_cnt_reg    <= '0;
      rx_idx_reg    <= '0;
      rx_shift_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      rx_sync1_reg  <= bit_in;
      rx_sync2_reg  <= rx_sync1_reg;
      rx_prev_reg   <= rx_sync2_reg;
      rx_state_reg  <= rx_state_next;
      rx_cnt_reg    <= rx_cnt_next;
      rx_idx_reg    <= rx_idx_next;
      rx_shift_reg  <= rx_shift_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  // Timing is anchored only to the start edge; data-bit edges are ignored.
  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      ST_IDLE:  if (rx_prev_reg && !rx_sync2_reg) rx_state_next = ST_START;
      ST_START: if (rx_half_end) rx_state_next = rx_sync2_reg ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_bit_end && rx_idx_reg == 3'd7) rx_state_next = ST_STOP;
      ST_STOP:  if (rx_bit_end) rx_state_next = ST_IDLE;
      default:  rx_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_next    = rx_cnt_reg + CNT_W'(1);
    rx_idx_next    = rx_idx_reg;
    rx_shift_next  = rx_shift_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg && !byte_out_ready;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;
    case (rx_state_reg)
      ST_IDLE: begin
        rx_cnt_next = '0;
        rx_idx_next = '0;
      end
      ST_START: if (rx_half_end) rx_cnt_next = '0;
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync2_reg, rx_shift_reg[7:1]};
          rx_idx_next   = rx_idx_reg + 3'd1;
        end
      end
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_next = '0;
          if (!rx_sync2_reg) begin
            frame_err_next = 1'b1;
          end else if (!out_valid_reg || byte_out_ready) begin
            // Holding register free, or being emptied on this same edge.
            out_data_next  = rx_shift_reg;
            out_valid_next = 1'b1;
          end else begin
            overrun_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign byte_out_data  = out_data_reg;
  assign byte_out_valid = out_valid_reg;
  assign rx_frame_err   = frame_err_reg;
  assign rx_overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_link.sv
// Testbench for uart_link at default parameters (33 clocks per bit).
module tb_uart_link;
  localparam int CPB = 33;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in_data = 8'h00;
  logic       byte_in_valid = 1'b0;
  logic       byte_in_ready;
  logic       bit_out;
  logic       bit_in;
  logic [7:0] byte_out_data;
  logic       byte_out_valid;
  logic       byte_out_ready = 1'b0;
  logic       rx_frame_err;
  logic       rx_overrun;

  logic loop_en = 1'b1;
  logic tb_line = 1'b1;
  assign bit_in = loop_en ? bit_out : tb_line;

  uart_link dut (
    .clk            (clk),
    .rst            (rst),
    .byte_in_data   (byte_in_data),
    .byte_in_valid  (byte_in_valid),
    .byte_in_ready  (byte_in_ready),
    .bit_out        (bit_out),
    .bit_in         (bit_in),
    .byte_out_data  (byte_out_data),
    .byte_out_valid (byte_out_valid),
    .byte_out_ready (byte_out_ready),
    .rx_frame_err   (rx_frame_err),
    .rx_overrun     (rx_overrun)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fail_cnt  = 0;
  int cyc_cnt   = 0;
  int err_total = 0;
  int ovr_total = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) begin
    if (rx_frame_err) err_total <= err_total + 1;
    if (rx_overrun)   ovr_total <= ovr_total + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_ready(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (byte_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (byte_out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      tb_line = f[b];
      repeat (CPB) @(posedge clk);
    end
    tb_line = 1'b1;
  endtask

  task automatic pulse_out_ready();
    @(negedge clk);
    byte_out_ready = 1'b1;
    @(negedge clk);
    byte_out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       consume;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_err;
    int         exp_ovr;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] stream [4];
  int         acc_t [4];

  initial begin
    bit ok;
    int first_ready, first_valid, e0, o0;
    logic [7:0] got;
    logic [9:0] pat;

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0}; // framing error, nothing held
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 0}; // good frame after error
    vecs[2] = '{8'h12, 1'b1, 1'b1, 1'b1, 8'h12, 0, 0}; // consume 3C, receive 12
    vecs[3] = '{8'h34, 1'b1, 1'b0, 1'b1, 8'h12, 0, 1}; // overrun, 12 kept
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h12, 1, 0}; // framing error while full
    vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 0, 0}; // consume 12, receive 81
    stream = '{8'h00, 8'hFF, 8'h55, 8'h80};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_bit_out", 32'(bit_out), 32'd1);
    check("rst_in_ready", 32'(byte_in_ready), 32'd0);
    check("rst_out_valid", 32'(byte_out_valid), 32'd0);
    check("rst_out_data", 32'(byte_out_data), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);

    // ---- loopback 0xA5 ----
    rst = 1'b0;
    wait_ready(3, ok);
    check("ready_after_rst", 32'(ok), 32'd1);
    byte_in_data  = 8'hA5;
    byte_in_valid = 1'b1;
    @(posedge clk); #1;
    byte_in_valid = 1'b0;
    first_ready = 0;
    first_valid = 0;
    got = 8'h00;
    pat = 10'b11_0100_1010;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      if (first_ready == 0 && byte_in_ready) first_ready = cyc;
      if (first_valid == 0 && byte_out_valid) begin
        first_valid = cyc;
        got = byte_out_data;
      end
      if (cyc % CPB == 16 && cyc / CPB < 10)
        check($sformatf("a5_bit%0d", cyc / CPB), 32'(bit_out), 32'(pat[cyc / CPB]));
    end
    check("a5_ready_low_cycles", 32'(first_ready), 32'd330);
    tests_run++;
    if (first_valid < 310 || first_valid > 320) begin
      fail_cnt++;
      $display("FAIL a5_rx_latency: got %0d required 310..320", first_valid);
    end else begin
      $display("[TB] ok a5_rx_latency = %0d", first_valid);
    end
    check("a5_rx_data", 32'(got), 32'hA5);
    @(negedge clk);
    byte_out_ready = 1'b1;
    @(posedge clk); #1;
    check("a5_valid_clears", 32'(byte_out_valid), 32'd0);
    byte_out_ready = 1'b0;

    // ---- loopback streaming ----
    e0 = err_total;
    o0 = ovr_total;
    byte_out_ready = 1'b1;
    fork
      begin
        bit okd;
        byte_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
          byte_in_data = stream[i];
          wait_ready(400, okd);
          if (!okd) check($sformatf("stream_tx_timeout%0d", i), 32'd0, 32'd1);
          @(posedge clk); #1;
          acc_t[i] = cyc_cnt;
        end
        byte_in_valid = 1'b0;
      end
      begin
        bit okr;
        for (int j = 0; j < 4; j++) begin
          wait_valid(800, okr);
          if (!okr) check($sformatf("stream_rx_timeout%0d", j), 32'd0, 32'd1);
          check($sformatf("stream_rx%0d", j), 32'(byte_out_data), 32'(stream[j]));
          @(posedge clk);
        end
      end
    join
    byte_out_ready = 1'b0;
    for (int i = 1; i < 4; i++)
      check($sformatf("stream_gap%0d", i), 32'(acc_t[i] - acc_t[i-1]), 32'd331);
    check("stream_no_err", 32'(err_total - e0), 32'd0);
    check("stream_no_ovr", 32'(ovr_total - o0), 32'd0);

    // ---- table: bench-driven frames ----
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    loop_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].consume) pulse_out_ready();
      e0 = err_total;
      o0 = ovr_total;
      repeat (10) @(negedge clk);
      send_frame(vecs[i].data, vecs[i].stop);
      repeat (5) @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(byte_out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 32'(byte_out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_err_pulses", i), 32'(err_total - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_ovr_pulses", i), 32'(ovr_total - o0), 32'(vecs[i].exp_ovr));
    end
    @(negedge clk);
    byte_out_ready = 1'b1;
    @(posedge clk); #1;
    check("consume_clears", 32'(byte_out_valid), 32'd0);
    byte_out_ready = 1'b0;

    // ---- 10-cycle glitch, then a frame 20 cycles after it began ----
    repeat (10) @(negedge clk);
    e0 = err_total;
    tb_line = 1'b0;
    repeat (10) @(posedge clk);
    tb_line = 1'b1;
    repeat (10) @(posedge clk);
    check("glitch_no_valid", 32'(byte_out_valid), 32'd0);
    check("glitch_no_err", 32'(err_total - e0), 32'd0);
    send_frame(8'hE7, 1'b1);
    repeat (5) @(negedge clk);
    check("post_glitch_valid", 32'(byte_out_valid), 32'd1);
    check("post_glitch_data", 32'(byte_out_data), 32'hE7);

    // ---- reset in the middle of a TX frame ----
    loop_en = 1'b1;
    wait_ready(5, ok);
    check("pre_rst_ready", 32'(ok), 32'd1);
    byte_in_data  = 8'h99;
    byte_in_valid = 1'b1;
    @(posedge clk); #1;
    byte_in_valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_bit_out", 32'(bit_out), 32'd1);
    check("midrst_in_ready", 32'(byte_in_ready), 32'd0);
    check("midrst_out_valid", 32'(byte_out_valid), 32'd0);
    check("midrst_out_data", 32'(byte_out_data), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ready(3, ok);
    check("post_rst_ready", 32'(ok), 32'd1);
    byte_in_data  = 8'hC3;
    byte_in_valid = 1'b1;
    @(posedge clk); #1;
    byte_in_valid = 1'b0;
    wait_valid(400, ok);
    check("c3_rx_valid", 32'(ok), 32'd1);
    check("c3_rx_data", 32'(byte_out_data), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
